// File: rtl/dsp_pkg.sv
// Shared types, widths and arithmetic helpers for the ANC accumulation path.
package dsp_pkg;

    localparam int IN_W       = 40;
    localparam int OUT_W      = 64;
    localparam int FRAC_SHIFT = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } sched_state_t;

    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic [OUT_W-1:0] sum;
        logic             clamped;
    } sat_res_t;

    // Left-align a signed product into the accumulator domain; the sign bit
    // lands on the accumulator MSB because IN_W + FRAC_SHIFT == OUT_W.
    function automatic logic [OUT_W-1:0] align_in(input logic [IN_W-1:0] d);
        return {d, {FRAC_SHIFT{1'b0}}};
    endfunction

    // Signed add with one guard bit; clamp when the guard and MSB disagree.
    function automatic sat_res_t sat_add(input logic [OUT_W-1:0] a,
                                         input logic [OUT_W-1:0] b);
        logic [OUT_W:0] s;
        sat_res_t       r;
        s         = {a[OUT_W-1], a} + {b[OUT_W-1], b};
        r.clamped = s[OUT_W] ^ s[OUT_W-1];
        if (r.clamped) begin
            r.sum = s[OUT_W] ? SAT_MIN : SAT_MAX;
        end else begin
            r.sum = s[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, circular.
module dsp_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    logic            found;
    int              pos;
    logic [ID_W-1:0] idx;

    // Walk the ring starting at ptr and keep the first asserted request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = ID_W'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dsp_accum_scheduler.sv
// Round-robin shared aligner + saturating accumulator for N tap-product streams.
//
// Handshakes: a beat (or result) moves on a rising edge where valid & ready
// are both high. A source holds valid and its payload steady until that edge;
// ready may be high before valid. req_ready is registered and at most one-hot.
module dsp_accum_scheduler
    import dsp_pkg::*;
#(
    parameter int   N_REQ      = 4,
    parameter int   IN_W       = dsp_pkg::IN_W,
    parameter int   OUT_W      = dsp_pkg::OUT_W,
    parameter int   FRAC_SHIFT = dsp_pkg::FRAC_SHIFT,
    localparam int  ID_W       = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IN_W-1:0] req_data,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_sat,
    output logic                  busy,
    output sched_state_t          dbg_state
);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [OUT_W-1:0] acc;
    logic             sat;

    logic [N_REQ-1:0] arb_grant;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_any;

    logic [IN_W-1:0]  beat;
    logic             beat_fire;
    logic             beat_last;
    sat_res_t         sum_res;

    dsp_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Select the granted stream's beat and form the next saturated sum.
    always_comb begin
        beat      = req_data[int'(grant_idx)*IN_W +: IN_W];
        beat_fire = |(req_valid & req_ready);
        beat_last = req_last[grant_idx];
        sum_res   = sat_add(acc, align_in(beat));
    end

    // Scheduler FSM: grant in IDLE, sum the locked packet, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            req_ready <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_idx <= arb_idx;
                        req_ready <= arb_grant;
                        acc       <= '0;
                        sat       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_fire) begin
                        acc <= sum_res.sum;
                        sat <= sat | sum_res.clamped;
                        if (beat_last) begin
                            req_ready <= '0;
                            out_valid <= 1'b1;
                            out_data  <= sum_res.sum;
                            out_id    <= grant_idx;
                            out_sat   <= sat | sum_res.clamped;
                            state     <= OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rr_ptr    <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dsp_accum_scheduler.sv
// Bench for dsp_accum_scheduler: directed packets plus randomized traffic,
// checked every cycle against a packet-level round-robin/saturation model.
module tb_dsp_accum_scheduler;

    localparam int N_REQ = 4;
    localparam int IN_W  = 40;
    localparam int OUT_W = 64;
    localparam int ID_W  = 2;

    typedef logic [IN_W-1:0] pkt_t [8];
    typedef int gap_t [8];
    typedef enum {M_IDLE, M_ACC, M_OUT} mph_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]      req_valid = '0;
    logic [N_REQ*IN_W-1:0] req_data  = '0;
    logic [N_REQ-1:0]      req_last  = '0;
    logic [N_REQ-1:0]      req_ready;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [OUT_W-1:0]      out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_sat;
    logic                  busy;
    dsp_pkg::sched_state_t dbg_state;

    dsp_accum_scheduler #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_sat   (out_sat),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- stimulus / model state ----------------
    logic [IN_W-1:0] bq [N_REQ][$];
    logic            lq [N_REQ][$];
    int              gq [N_REQ][$];
    int              stall_cnt [N_REQ];
    logic [64:0]     exp_q [N_REQ][$];
    logic [72:0]     hs_q [$];
    int              bp_mode = 1;
    gap_t            zg = '{default:0};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet sum from plain wide signed arithmetic with clamping at each beat.
    function automatic logic [64:0] model_pkt(input pkt_t b, input int n);
        logic signed [127:0] acc;
        logic signed [127:0] beat;
        logic signed [127:0] maxv;
        logic signed [127:0] minv;
        logic                sat;
        maxv = (128'sd1 <<< 63) - 128'sd1;
        minv = -(128'sd1 <<< 63);
        acc  = 0;
        sat  = 1'b0;
        for (int i = 0; i < n; i++) begin
            beat = $signed(b[i]);
            acc  = acc + beat * 128'sd16777216;
            if (acc > maxv) begin acc = maxv; sat = 1'b1; end
            else if (acc < minv) begin acc = minv; sat = 1'b1; end
        end
        return {sat, acc[63:0]};
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return 0;
    endfunction

    function automatic bit all_empty();
        for (int r = 0; r < N_REQ; r++) begin
            if (bq[r].size() != 0 || exp_q[r].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_pkt(input int r, input pkt_t b, input int n, input gap_t g);
        for (int i = 0; i < n; i++) begin
            bq[r].push_back(b[i]);
            lq[r].push_back(i == n - 1);
            gq[r].push_back(g[i]);
        end
        exp_q[r].push_back(model_pkt(b, n));
    endtask

    task automatic drive_cycle();
        logic [N_REQ-1:0] fire;
        @(negedge clk);
        fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < N_REQ; r++) begin
            if (fire[r] && bq[r].size() != 0) begin
                stall_cnt[r] = gq[r][0];
                void'(bq[r].pop_front());
                void'(lq[r].pop_front());
                void'(gq[r].pop_front());
            end
            if (stall_cnt[r] > 0) begin
                req_valid[r] = 1'b0;
                stall_cnt[r]--;
            end else if (bq[r].size() != 0) begin
                req_valid[r] = 1'b1;
                req_data[r*IN_W +: IN_W] = bq[r][0];
                req_last[r] = lq[r][0];
            end else begin
                req_valid[r] = 1'b0;
                req_last[r]  = 1'b0;
            end
        end
        case (bp_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (!all_empty() && n < max_cyc) begin
            drive_cycle();
            n++;
        end
        chk("drain_done", all_empty(), 1'b1);
        repeat (2) drive_cycle();
    endtask

    task automatic chk_hs(input int i, input int id, input logic [64:0] e);
        if (i >= hs_q.size()) begin
            checks++;
            failures++;
            $display("FAIL hs_missing: got %0d results needed index %0d", hs_q.size(), i);
        end else begin
            chk("hs_id", hs_q[i][72:65], id);
            chk("hs_result", hs_q[i][64:0], e);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    mph_t             m_prev = M_IDLE;
    mph_t             now;
    int               m_ptr = 0;
    int               m_grant = 0;
    logic [N_REQ-1:0] p_valid = '0;
    logic             p_lastfire = 1'b0;
    logic             p_ohs = 1'b0;
    logic [N_REQ-1:0] exp_ready;

    // Each cycle: derive the expected phase from last cycle's inputs, then compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev     = M_IDLE;
            m_ptr      = 0;
            p_valid    = '0;
            p_lastfire = 1'b0;
            p_ohs      = 1'b0;
        end else begin
            case (m_prev)
                M_IDLE: begin
                    if (|p_valid) begin
                        now     = M_ACC;
                        m_grant = rr_pick(p_valid, m_ptr);
                    end else begin
                        now = M_IDLE;
                    end
                end
                M_ACC:   now = p_lastfire ? M_OUT : M_ACC;
                default: now = p_ohs ? M_IDLE : M_OUT;
            endcase
            exp_ready = (now == M_ACC) ? (N_REQ'(1) << m_grant) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("out_valid", out_valid, now == M_OUT);
            chk("busy", busy, now != M_IDLE);
            chk("dbg_idle", dbg_state == dsp_pkg::IDLE, now == M_IDLE);
            if (now == M_OUT) begin
                if (exp_q[m_grant].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got result id %0d expected none", out_id);
                end else begin
                    chk("out_id", out_id, m_grant);
                    chk("out_data", out_data, exp_q[m_grant][0][63:0]);
                    chk("out_sat", out_sat, exp_q[m_grant][0][64]);
                end
            end
            p_valid    = req_valid;
            p_lastfire = |(req_valid & exp_ready & req_last);
            p_ohs      = (now == M_OUT) && out_ready;
            if (p_ohs) begin
                hs_q.push_back({8'(out_id), out_sat, out_data});
                if (exp_q[m_grant].size() != 0) void'(exp_q[m_grant].pop_front());
                m_ptr = (m_grant + 1) % N_REQ;
            end
            m_prev = now;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        pkt_t p;
        gap_t g;
        logic [63:0] rnd;
        int n;
        int exp_ids [5] = '{0, 1, 2, 3, 0};

        for (int r = 0; r < N_REQ; r++) stall_cnt[r] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // model pins
        p = '{default:'0};
        p[0] = 40'd1; p[1] = 40'd2; p[2] = 40'd3;
        chk("pin_small", model_pkt(p, 3), {1'b0, 64'h0000_0000_0600_0000});
        p[0] = 40'h7F_FFFF_FFFF; p[1] = 40'h7F_FFFF_FFFF; p[2] = 40'hFF_FFFF_FFFF;
        chk("pin_pos_sat", model_pkt(p, 3), {1'b1, 64'h7FFF_FFFF_FEFF_FFFF});
        p[0] = 40'h80_0000_0000; p[1] = 40'h80_0000_0000;
        chk("pin_neg_sat", model_pkt(p, 2), {1'b1, 64'h8000_0000_0000_0000});

        // all four requesters with one-beat packets, requester 0 twice
        hs_q.delete();
        for (int r = 0; r < N_REQ; r++) begin
            p = '{default:'0};
            p[0] = IN_W'(r + 16);
            push_pkt(r, p, 1, zg);
        end
        p[0] = 40'd99;
        push_pkt(0, p, 1, zg);
        drain(200);
        chk("rr_count", hs_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < hs_q.size()) chk("rr_order", hs_q[i][72:65], exp_ids[i]);
        end

        // single requester, beats 1,2,3
        hs_q.delete();
        p = '{default:'0};
        p[0] = 40'd1; p[1] = 40'd2; p[2] = 40'd3;
        push_pkt(0, p, 3, zg);
        drain(100);
        chk_hs(0, 0, {1'b0, 64'h0000_0000_0600_0000});

        // positive then negative saturation
        hs_q.delete();
        p[0] = 40'h7F_FFFF_FFFF; p[1] = 40'h7F_FFFF_FFFF; p[2] = 40'hFF_FFFF_FFFF;
        push_pkt(1, p, 3, zg);
        drain(100);
        p[0] = 40'h80_0000_0000; p[1] = 40'h80_0000_0000;
        push_pkt(3, p, 2, zg);
        drain(100);
        chk_hs(0, 1, {1'b1, 64'h7FFF_FFFF_FEFF_FFFF});
        chk_hs(1, 3, {1'b1, 64'h8000_0000_0000_0000});

        // backpressure: result held for 10 cycles, requester 2 must wait
        hs_q.delete();
        bp_mode = 2;
        p = '{default:'0};
        p[0] = 40'h12345;
        push_pkt(1, p, 1, zg);
        p[0] = 40'h777;
        push_pkt(2, p, 1, zg);
        n = 0;
        while (!out_valid && n < 20) begin drive_cycle(); n++; end
        chk("bp_seen", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive_cycle();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", req_ready, 0);
        end
        bp_mode = 1;
        drain(100);
        chk_hs(0, 1, {1'b0, 64'h0000_0123_4500_0000});
        chk_hs(1, 2, {1'b0, 64'h0000_0000_0777_0000 << 8});

        // stall of 3 cycles inside requester 2's packet with requester 1 waiting
        hs_q.delete();
        p = '{default:'0};
        p[0] = 40'd5; p[1] = 40'd6; p[2] = 40'd7; p[3] = 40'd8;
        g = zg;
        g[1] = 3;
        push_pkt(2, p, 4, g);
        repeat (3) drive_cycle();
        p = '{default:'0};
        p[0] = 40'd4;
        push_pkt(1, p, 1, zg);
        drain(100);
        chk_hs(0, 2, {1'b0, 64'h0000_0000_1A00_0000});
        chk_hs(1, 1, {1'b0, 64'h0000_0000_0400_0000});

        // randomized traffic with random backpressure and stalls
        bp_mode = 0;
        for (int k = 0; k < 40; k++) begin
            p = '{default:'0};
            g = zg;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                rnd = {$urandom(), $urandom()};
                case ($urandom_range(0, 3))
                    0: p[i] = rnd[IN_W-1:0];
                    1: p[i] = 40'h7F_FFFF_FFFF - IN_W'($urandom_range(0, 255));
                    2: p[i] = 40'h80_0000_0000 + IN_W'($urandom_range(0, 255));
                    default: p[i] = IN_W'($signed(rnd[15:0]));
                endcase
                if ($urandom_range(0, 4) == 0) g[i] = $urandom_range(1, 3);
            end
            push_pkt($urandom_range(0, N_REQ - 1), p, n, g);
        end
        drain(6000);
        bp_mode = 1;

        // reset in the middle of requester 2's packet
        hs_q.delete();
        p = '{default:'0};
        p[0] = 40'd1;
        push_pkt(1, p, 1, zg);
        drain(100);
        p[0] = 40'd1; p[1] = 40'd2; p[2] = 40'd3; p[3] = 40'd4; p[4] = 40'd5; p[5] = 40'd6;
        push_pkt(2, p, 6, zg);
        repeat (4) drive_cycle();
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_id", out_id, 0);
        chk("mid_rst_out_sat", out_sat, 0);
        chk("mid_rst_busy", busy, 0);
        for (int r = 0; r < N_REQ; r++) begin
            bq[r].delete(); lq[r].delete(); gq[r].delete(); exp_q[r].delete();
            stall_cnt[r] = 0;
        end
        req_valid = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_q.delete();
        p = '{default:'0};
        p[0] = 40'd9;
        push_pkt(3, p, 1, zg);
        p[0] = 40'd10;
        push_pkt(1, p, 1, zg);
        drain(100);
        chk("post_rst_count", hs_q.size(), 2);
        chk_hs(0, 1, {1'b0, 64'h0000_0000_0A00_0000});
        chk_hs(1, 3, {1'b0, 64'h0000_0000_0900_0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsp_accum_scheduler.md
# dsp_accum_scheduler

Round-robin scheduler that shares one 40-to-64-bit alignment stage and one saturating 64-bit accumulator among N requesters (FIR/LMS tap-product streams in the ANC path). Each requester streams a packet of signed Q-format 40-bit products. The block left-aligns each product by 24 bits into the 64-bit accumulator domain, sums the packet, and returns one 64-bit result tagged with the requester ID. It sits between the per-channel multiplier outputs and the ANC filter-update/output logic.

## Interface
- N_REQ, 4, number of requesters (2..8)
- IN_W, 40, signed input product width
- OUT_W, 64, signed accumulator/result width
- FRAC_SHIFT, 24, left alignment shift; IN_W + FRAC_SHIFT must equal OUT_W
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*IN_W  per-requester signed beat; requester i in bits [i*IN_W +: IN_W]
- req_last  in  N_REQ  marks final beat of a packet
- req_ready  out  N_REQ  one-hot or zero; beat accepted when valid & ready
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed accumulated, saturated result
- out_id  out  clog2(N_REQ)  requester that produced out_data
- out_sat  out  1  saturation occurred in this packet
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE: if any req_valid is high, grant the first requester at or after rr_ptr (circular). Load acc=0 and sat=0, then go to ACCUM. With no requests, stay in IDLE.
- ACCUM: req_ready[grant]=1, all other bits 0. Grant is locked until the packet ends.
  - Each accepted beat: aligned = sign-correct {req_data, FRAC_SHIFT zeros}, and acc = sat_add(acc, aligned).
  - A beat with req_last goes to OUTPUT.
  - Cycles without valid are stalls; acc holds.
- sat_add: a 65-bit signed sum clamps to 0x7FFF_FFFF_FFFF_FFFF or 0x8000_0000_0000_0000. Any clamp sets sticky sat. A clamped acc keeps accumulating from the clamped value.
- OUTPUT: out_valid=1, with out_data=acc, out_id=grant and out_sat=sat, all stable until out_ready.
  - On out_valid & out_ready, set rr_ptr = grant+1 mod N_REQ and go to IDLE.
  - req_ready is 0 for the whole of OUTPUT.
- Single-beat packets (valid & last on the first beat) are legal.
- Reset (asynchronous, any state) clears everything below; an in-flight packet is discarded with no partial result emitted:
  - state=IDLE, rr_ptr=0, acc=0, sat=0
  - req_ready=0, out_valid=0, out_data=0, out_id=0, out_sat=0, busy=0

## Timing
- Grant decision: 1 cycle in IDLE. req_ready[grant] rises the cycle after the request is seen.
- Throughput in ACCUM: 1 beat per cycle.
- Last beat accepted in cycle k means out_valid=1 in cycle k+1.
- Minimum packet period: 1 cycle IDLE + L beats + 1 cycle OUTPUT (with out_ready held high).
- Requester protocol: req_valid/req_data/req_last must be held until accepted. The block never depends on req_valid deasserting.
- out_ready may be high before out_valid. A result is transferred on exactly one cycle.
- A requester raising req_valid while another is granted waits. Fairness: every pending requester is served within N_REQ packets.

## Structure
- Package dsp_pkg holds:
  - IN_W, OUT_W and FRAC_SHIFT defaults
  - the state enum sched_state_t {IDLE, ACCUM, OUTPUT}
  - SAT_MAX and SAT_MIN constants
  - function align_in (IN_W to OUT_W, left shift)
  - function sat_add
- One sub-module, dsp_rr_arbiter:
  - inputs: request vector, rr_ptr
  - outputs: one-hot grant, grant index
  - purely combinational
- The top level holds the FSM, accumulator and output register.

## Test plan
- Single requester 0, beats 1, 2, 3 (last on 3): out_data = 6<<24 = 0x0000_0000_0600_0000, out_id=0, out_sat=0, out_valid the cycle after the last beat.
- Requesters 0..3 all valid continuously, one-beat packets: out_id sequence is 0,1,2,3,0. req_ready is never multi-hot.
- Overflow: two beats of 0x7F_FFFF_FFFF, then one beat of -1 -> out_data = 0x7FFF_FFFF_FFFF_FFFF - 0x100_0000, out_sat=1. Negative case: two beats of 0x80_0000_0000 -> 0x8000_0000_0000_0000, out_sat=1.
- Backpressure: out_ready held low for 10 cycles -> out_valid, out_data and out_id stay stable, and req_ready stays 0 throughout. The next grant occurs only after the handshake.
- Stalls: requester 2 deasserts valid for 3 cycles mid-packet -> grant stays on 2 and the sum is unaffected. Requester 1 pending during the stall is not granted until after requester 2's result.
- rst_n pulsed low mid-ACCUM -> all outputs 0 immediately. After release, a new packet on requester 3 is granted with rr_ptr=0 search order, and its result contains no stale accumulation.
